safecrack_pro_fsm: RTL and testbench

- Parametrised SafeCrack Pro lock controller: configurable code length, button count and timings; user-programmable code; failed-attempt lockout.
- Sits between the board push-buttons and the LEDG/LEDR banks. Drives progress, open, error and lockout indication plus an `unlocked` strobe to the rest of the design.

---
 rtl/safecrack_pro_fsm.sv | 188 ++++++++++++++++++
 tb/tb_safecrack_pro_fsm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/safecrack_pro_fsm.sv
// rtl/safecrack_pro_fsm.sv - SafeCrack Pro lock controller with programmable code and lockout
module safecrack_pro_fsm #(
  parameter int          NUM_BTN        = 4,
  parameter int          CODE_LEN       = 3,
  parameter logic [23:0] DEFAULT_CODE   = 24'h24,
  parameter int          ERR_CYCLES     = 150_000_000,
  parameter int          OPEN_CYCLES    = 250_000_000,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 500_000_000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_BTN-1:0] btn_n,
  input  logic               prog_en,
  output logic [8:0]         leds_green,
  output logic [17:0]        leds_red,
  output logic               unlocked,
  output logic               locked_out,
  output logic [3:0]         fail_cnt
);

  localparam int DW    = $clog2(NUM_BTN);
  localparam int CW    = CODE_LEN * DW;
  localparam int MAX_A = (ERR_CYCLES > OPEN_CYCLES) ? ERR_CYCLES : OPEN_CYCLES;
  localparam int MAXT  = (MAX_A > LOCKOUT_CYCLES) ? MAX_A : LOCKOUT_CYCLES;
  localparam int TW    = ($clog2(MAXT) < 1) ? 1 : $clog2(MAXT);
  localparam int IW    = $clog2(CODE_LEN + 1);

  localparam logic [2:0] ENTRY   = 3'd0;
  localparam logic [2:0] ERROR   = 3'd1;
  localparam logic [2:0] OPEN    = 3'd2;
  localparam logic [2:0] PROG    = 3'd3;
  localparam logic [2:0] LOCKOUT = 3'd4;

  logic [2:0]         state;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      pidx;
  logic [CW-1:0]      code_reg;
  logic [CW-1:0]      shadow;
  logic [CW-1:0]      shadow_next;
  logic [TW-1:0]      timer;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] prev;
  logic [NUM_BTN-1:0] edges;
  logic               any_edge;
  logic               valid_digit;
  logic [DW-1:0]      digit;
  logic [3:0]         fail_inc;

  // Synchronise the inverted buttons and keep a delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= ~btn_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edges       = sync2 & ~prev;
  assign any_edge    = |edges;
  assign valid_digit = any_edge && ((edges & (edges - NUM_BTN'(1))) == '0);
  assign fail_inc    = (fail_cnt == 4'hF) ? fail_cnt : fail_cnt + 4'd1;

  // Encode the single pressed button into a digit and merge it into the programming shadow
  always_comb begin
    digit       = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (edges[i]) digit = DW'(i);
    end
    shadow_next = shadow;
    shadow_next[pidx*DW +: DW] = digit;
  end

  // Main lock state machine with code, fail counter and dwell timer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ENTRY;
      idx      <= '0;
      pidx     <= '0;
      code_reg <= DEFAULT_CODE[CW-1:0];
      shadow   <= '0;
      fail_cnt <= '0;
      timer    <= '0;
    end else begin
      case (state)
        ENTRY: begin
          if (any_edge) begin
            if (valid_digit && (digit == code_reg[idx*DW +: DW])) begin
              if (idx == IW'(CODE_LEN - 1)) begin
                state    <= OPEN;
                idx      <= '0;
                fail_cnt <= '0;
                timer    <= TW'(OPEN_CYCLES - 1);
              end else begin
                idx <= idx + IW'(1);
              end
            end else begin
              fail_cnt <= fail_inc;
              idx      <= '0;
              if (fail_inc == 4'(MAX_FAILS)) begin
                state <= LOCKOUT;
                timer <= TW'(LOCKOUT_CYCLES - 1);
              end else begin
                state <= ERROR;
                timer <= TW'(ERR_CYCLES - 1);
              end
            end
          end
        end
        ERROR: begin
          if (timer == '0) begin
            state <= ENTRY;
            idx   <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        OPEN: begin
          if (prog_en) begin
            state <= PROG;
            pidx  <= '0;
          end else if (timer == '0) begin
            state <= ENTRY;
            idx   <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        PROG: begin
          if (!prog_en) begin
            state <= ENTRY;
            idx   <= '0;
          end else if (valid_digit) begin
            shadow <= shadow_next;
            if (pidx == IW'(CODE_LEN - 1)) begin
              code_reg <= shadow_next;
              state    <= ENTRY;
              idx      <= '0;
            end else begin
              pidx <= pidx + IW'(1);
            end
          end
        end
        LOCKOUT: begin
          if (timer == '0) begin
            state    <= ENTRY;
            idx      <= '0;
            fail_cnt <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state <= ENTRY;
          idx   <= '0;
        end
      endcase
    end
  end

  // Decode LED banks from the registered state and digit counters
  always_comb begin
    leds_green = '0;
    leds_red   = '0;
    case (state)
      ENTRY: begin
        for (int i = 0; i < 8; i++) leds_green[i] = (i <= int'(idx));
      end
      OPEN:    leds_green = 9'h1FF;
      PROG: begin
        leds_green[8] = 1'b1;
        for (int i = 0; i < 8; i++) leds_green[i] = (i < int'(pidx));
      end
      ERROR:   leds_red[0] = 1'b1;
      LOCKOUT: leds_red = 18'h3FFFF;
      default: leds_green = '0;
    endcase
  end

  assign unlocked   = (state == OPEN) || (state == PROG);
  assign locked_out = (state == LOCKOUT);

endmodule

// File: tb/tb_safecrack_pro_fsm.sv
// tb/tb_safecrack_pro_fsm.sv - scoreboard bench for safecrack_pro_fsm
module tb_safecrack_pro_fsm;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  btn_n;
  logic        prog_en;
  logic [8:0]  leds_green;
  logic [17:0] leds_red;
  logic        unlocked;
  logic        locked_out;
  logic [3:0]  fail_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [32:0] val;
    int          dwell;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [32:0] cur;
  logic [32:0] last;
  bit          have = 1'b0;
  int          cnt = 0;
  int          last_dwell = 0;
  string       last_name = "none";

  safecrack_pro_fsm #(
    .NUM_BTN(4), .CODE_LEN(3), .DEFAULT_CODE(24'h24),
    .ERR_CYCLES(10), .OPEN_CYCLES(20), .MAX_FAILS(3), .LOCKOUT_CYCLES(40)
  ) dut (
    .clk(clk), .rstn(rstn), .btn_n(btn_n), .prog_en(prog_en),
    .leds_green(leds_green), .leds_red(leds_red), .unlocked(unlocked),
    .locked_out(locked_out), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic ex(input string n, input logic [8:0] g, input logic [17:0] r,
                    input logic u, input logic l, input logic [3:0] f, input int d);
    exp_t t;
    t.name  = n;
    t.val   = {g, r, u, l, f};
    t.dwell = d;
    q.push_back(t);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    @(posedge clk);
    #1 btn_n = ~m;
    repeat (hold) @(posedge clk);
    #1 btn_n = 4'hF;
    repeat (4) @(posedge clk);
  endtask

  // Monitor: every change of the output snapshot pops one expected entry
  initial begin
    forever begin
      @(negedge clk);
      cur = {leds_green, leds_red, unlocked, locked_out, fail_cnt};
      if (!have || cur !== last) begin
        if (have && last_dwell != 0) begin
          total++;
          if (cnt != last_dwell) begin
            bad++;
            $display("FAIL dwell_%s: held %0d cycles, required %0d", last_name, cnt, last_dwell);
          end
        end
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got %h, required no change", cur);
          last_dwell = 0;
          last_name  = "unexpected";
        end else begin
          e = q.pop_front();
          total++;
          if (cur !== e.val) begin
            bad++;
            $display("FAIL %s: got g=%h r=%h u=%b l=%b f=%0d, required g=%h r=%h u=%b l=%b f=%0d",
                     e.name, cur[32:24], cur[23:6], cur[5], cur[4], cur[3:0],
                     e.val[32:24], e.val[23:6], e.val[5], e.val[4], e.val[3:0]);
          end
          last_dwell = e.dwell;
          last_name  = e.name;
        end
        last = cur;
        have = 1'b1;
        cnt  = 1;
      end else begin
        cnt++;
      end
    end
  end

  // Stimulus: directed scenarios, each preceded by its expected output events
  initial begin
    btn_n   = 4'hF;
    prog_en = 1'b0;
    rstn    = 1'b0;
    ex("reset", 9'h001, 18'h0, 0, 0, 4'd0, 0);
    idle(3);
    #1 rstn = 1'b1;

    ex("ok_d0", 9'h003, 18'h0, 0, 0, 4'd0, 0);   press(4'b0001, 3);
    ex("ok_d1", 9'h007, 18'h0, 0, 0, 4'd0, 0);   press(4'b0010, 3);
    ex("ok_open", 9'h1FF, 18'h0, 1, 0, 4'd0, 20);
    ex("ok_close", 9'h001, 18'h0, 0, 0, 4'd0, 0); press(4'b0100, 3);
    idle(25);

    ex("w_d0", 9'h003, 18'h0, 0, 0, 4'd0, 0);    press(4'b0001, 3);
    ex("w_err", 9'h000, 18'h1, 0, 0, 4'd1, 10);
    ex("w_back", 9'h001, 18'h0, 0, 0, 4'd1, 0);  press(4'b1000, 3);
    idle(12);

    ex("m_d0", 9'h003, 18'h0, 0, 0, 4'd1, 0);    press(4'b0001, 3);
    ex("m_err", 9'h000, 18'h1, 0, 0, 4'd2, 10);
    ex("m_back", 9'h001, 18'h0, 0, 0, 4'd2, 0);  press(4'b0011, 3);
    idle(12);

    ex("lk_on", 9'h000, 18'h3FFFF, 0, 1, 4'd3, 40);
    ex("lk_off", 9'h001, 18'h0, 0, 0, 4'd0, 0);  press(4'b1000, 3);
    press(4'b0001, 3);
    press(4'b0010, 3);
    press(4'b0100, 3);
    idle(30);

    ex("p_d0", 9'h003, 18'h0, 0, 0, 4'd0, 0);    press(4'b0001, 3);
    ex("p_d1", 9'h007, 18'h0, 0, 0, 4'd0, 0);    press(4'b0010, 3);
    ex("p_open", 9'h1FF, 18'h0, 1, 0, 4'd0, 0);  press(4'b0100, 3);
    ex("p_prog", 9'h100, 18'h0, 1, 0, 4'd0, 0);
    @(posedge clk); #1 prog_en = 1'b1;
    ex("p_c0", 9'h101, 18'h0, 1, 0, 4'd0, 0);    press(4'b1000, 3);
    ex("p_c1", 9'h103, 18'h0, 1, 0, 4'd0, 0);    press(4'b1000, 3);
    ex("p_done", 9'h001, 18'h0, 0, 0, 4'd0, 0);  press(4'b0010, 3);
    @(posedge clk); #1 prog_en = 1'b0;
    idle(3);

    ex("n_old_err", 9'h000, 18'h1, 0, 0, 4'd1, 10);
    ex("n_old_back", 9'h001, 18'h0, 0, 0, 4'd1, 0); press(4'b0001, 3);
    idle(12);
    ex("n_d0", 9'h003, 18'h0, 0, 0, 4'd1, 0);    press(4'b1000, 3);
    ex("n_d1", 9'h007, 18'h0, 0, 0, 4'd1, 0);    press(4'b1000, 3);
    ex("n_open", 9'h1FF, 18'h0, 1, 0, 4'd0, 20);
    ex("n_close", 9'h001, 18'h0, 0, 0, 4'd0, 0); press(4'b0010, 3);
    idle(25);

    ex("a_d0", 9'h003, 18'h0, 0, 0, 4'd0, 0);    press(4'b1000, 3);
    ex("a_d1", 9'h007, 18'h0, 0, 0, 4'd0, 0);    press(4'b1000, 3);
    ex("a_open", 9'h1FF, 18'h0, 1, 0, 4'd0, 0);  press(4'b0010, 3);
    ex("a_prog", 9'h100, 18'h0, 1, 0, 4'd0, 0);
    @(posedge clk); #1 prog_en = 1'b1;
    ex("a_c0", 9'h101, 18'h0, 1, 0, 4'd0, 0);    press(4'b0100, 3);
    ex("a_abort", 9'h001, 18'h0, 0, 0, 4'd0, 0);
    @(posedge clk); #1 prog_en = 1'b0;
    idle(3);
    ex("a2_d0", 9'h003, 18'h0, 0, 0, 4'd0, 0);   press(4'b1000, 3);
    ex("a2_d1", 9'h007, 18'h0, 0, 0, 4'd0, 0);   press(4'b1000, 3);
    ex("a2_open", 9'h1FF, 18'h0, 1, 0, 4'd0, 20);
    ex("a2_close", 9'h001, 18'h0, 0, 0, 4'd0, 0); press(4'b0010, 3);
    idle(25);

    ex("r_d0", 9'h003, 18'h0, 0, 0, 4'd0, 0);    press(4'b1000, 3);
    ex("r_d1", 9'h007, 18'h0, 0, 0, 4'd0, 0);    press(4'b1000, 3);
    ex("r_open", 9'h1FF, 18'h0, 1, 0, 4'd0, 0);  press(4'b0010, 3);
    ex("r_reset", 9'h001, 18'h0, 0, 0, 4'd0, 0);
    @(posedge clk); #1 rstn = 1'b0;
    idle(2);
    #1 rstn = 1'b1;
    idle(3);
    ex("d_d0", 9'h003, 18'h0, 0, 0, 4'd0, 0);    press(4'b0001, 3);
    ex("d_d1", 9'h007, 18'h0, 0, 0, 4'd0, 0);    press(4'b0010, 3);
    ex("d_open", 9'h1FF, 18'h0, 1, 0, 4'd0, 20);
    ex("d_close", 9'h001, 18'h0, 0, 0, 4'd0, 0); press(4'b0100, 3);
    idle(25);

    ex("h_d0", 9'h003, 18'h0, 0, 0, 4'd0, 0);    press(4'b0001, 100);
    idle(10);

    idle(5);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events: %0d pending, required 0 (next %s)", q.size(), q[0].name);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
